// File: rtl/matrix_packer.sv
// matrix_packer
//   Packs the valid-qualified dibit stream from matrix_loader into matrix
//   elements and writes them row-major into a ROWS x COLS buffer.
//   Dibits fill a byte LSB-first; bytes fill an element MSB-first.
//   complete pulses with the write of the final element; error pulses when
//   a frame ends before the matrix is full.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   axiiv, axiid      dibit valid / dibit data
//   wr_en             one-cycle buffer write strobe per element
//   wr_addr, wr_data  element address (row*COLS+col) and assembled element
//   row, col          position of the next element to be written
//   busy              high while loading or draining a frame
//   complete, error   one-cycle frame status pulses
module matrix_packer #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ELEM_BYTES = 1,
    localparam int DW        = 8 * ELEM_BYTES,
    localparam int AW        = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          axiiv,
    input  logic [1:0]    axiid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          busy,
    output logic          complete,
    output logic          error
);

    localparam int DIBITS = 4 * ELEM_BYTES;
    localparam int DCW    = $clog2(DIBITS);

    localparam logic [DCW-1:0] LAST_DIBIT = DCW'(DIBITS - 1);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(ROWS * COLS - 1);
    localparam logic [CW-1:0]  LAST_COL   = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t         state_q;
    state_t         state_next;
    logic           consume;
    logic           take_error;
    logic           element_done;
    logic           last_elem;
    logic [DCW-1:0] dibit_cnt_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  elem_q;
    logic [DW-1:0]  elem_next;

    assign busy         = (state_q != IDLE);
    assign element_done = consume && (dibit_cnt_q == LAST_DIBIT);
    assign last_elem    = (addr_q == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic. In LOAD, a high 'complete' marks the write cycle of
    // the final element: the frame is already satisfied, so a drop of axiiv
    // here is a clean end rather than a truncation, and any further dibit is
    // surplus for DRAIN to swallow.
    always_comb begin
        state_next = state_q;
        consume    = 1'b0;
        take_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (axiiv) begin
                    consume    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (complete) begin
                    state_next = axiiv ? DRAIN : IDLE;
                end else if (axiiv) begin
                    consume = 1'b1;
                end else begin
                    take_error = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (!axiiv) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Drop the incoming dibit straight into its final bit position so the
    // element is complete on the same edge its last dibit is sampled.
    always_comb begin
        elem_next = elem_q;
        for (int i = 0; i < DIBITS; i++) begin
            if (dibit_cnt_q == DCW'(i)) begin
                elem_next[8 * (ELEM_BYTES - 1 - i / 4) + 2 * (i % 4) +: 2] = axiid;
            end
        end
    end

    // Datapath and registered outputs. Position counters are cleared in IDLE
    // and on truncation; the consume branch comes afterwards so the first
    // dibit of a frame taken in IDLE still advances the dibit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            row         <= '0;
            col         <= '0;
            complete    <= 1'b0;
            error       <= 1'b0;
            dibit_cnt_q <= '0;
            addr_q      <= '0;
            elem_q      <= '0;
        end else begin
            wr_en    <= element_done;
            complete <= element_done && last_elem;
            error    <= take_error;

            if (state_q == IDLE || take_error) begin
                dibit_cnt_q <= '0;
                addr_q      <= '0;
                row         <= '0;
                col         <= '0;
            end

            if (consume) begin
                elem_q      <= elem_next;
                dibit_cnt_q <= element_done ? '0 : dibit_cnt_q + DCW'(1);
            end

            if (element_done) begin
                wr_addr <= addr_q;
                wr_data <= elem_next;
                if (last_elem) begin
                    addr_q <= '0;
                    row    <= '0;
                    col    <= '0;
                end else begin
                    addr_q <= addr_q + AW'(1);
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
        end
    end

endmodule
